conv_col_bram_writer: RTL and testbench

Write-back end of the convolution BRAM path. It accepts one output column per handshake, holding OUTPUT_CHANNELS × OUTPUT_COL_SIZE FP16 values, from the multi-channel convolution top. It packs each channel's column into 256-bit BRAM words and writes them sequentially into the PS-visible result BRAM. It counts columns per frame and pulses frame_done once the last column of a feature map has been written.

---
 rtl/conv_pkg.sv | 22 ++
 rtl/col_word_packer.sv | 43 ++++
 rtl/conv_col_bram_writer.sv | 166 ++++++++++++++++
 tb/tb_conv_col_bram_writer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution BRAM write-back path.
package conv_pkg;

  localparam int DATA_WIDTH_D      = 16;
  localparam int OUTPUT_CHANNELS_D = 4;
  localparam int OUTPUT_COL_SIZE_D = 24;
  localparam int NUM_COLS_D        = 24;
  localparam int BRAM_WIDTH_D      = 256;
  localparam int ADDR_WIDTH_D      = 12;

  typedef logic [DATA_WIDTH_D-1:0] fp16_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/col_word_packer.sv
// Selects one channel of a buffered column and packs word k into a BRAM-wide
// vector, zero-filling lanes past the end of the channel column.
module col_word_packer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_D,
  parameter int OUTPUT_CHANNELS = OUTPUT_CHANNELS_D,
  parameter int OUTPUT_COL_SIZE = OUTPUT_COL_SIZE_D,
  parameter int BRAM_WIDTH      = BRAM_WIDTH_D,
  localparam int LANES = BRAM_WIDTH / DATA_WIDTH,
  localparam int WPC   = ceil_div(OUTPUT_COL_SIZE, LANES),
  localparam int WPCOL = OUTPUT_CHANNELS * WPC,
  localparam int K_W   = (WPCOL > 1) ? $clog2(WPCOL) : 1
) (
  input  logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col,
  input  logic [K_W-1:0]                                                 k,
  output logic [BRAM_WIDTH-1:0]                                          word
);

  localparam int CH_W = (OUTPUT_CHANNELS > 1) ? $clog2(OUTPUT_CHANNELS) : 1;
  localparam int W_W  = (WPC > 1) ? $clog2(WPC) : 1;

  logic [CH_W-1:0]                              ch_s;
  logic [W_W-1:0]                               w_s;
  logic [OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0]   chan_s;
  logic [WPC-1:0][LANES-1:0][DATA_WIDTH-1:0]    padded_s;

  assign ch_s   = CH_W'(k / K_W'(WPC));
  assign w_s    = W_W'(k % K_W'(WPC));
  assign chan_s = col[ch_s];

  // Pad the channel column up to a whole number of BRAM words.
  for (genvar i = 0; i < WPC * LANES; i++) begin : g_pad
    if (i < OUTPUT_COL_SIZE) begin : g_data
      assign padded_s[i / LANES][i % LANES] = chan_s[i];
    end else begin : g_zero
      assign padded_s[i / LANES][i % LANES] = {DATA_WIDTH{1'b0}};
    end
  end

  assign word = padded_s[w_s];

endmodule

// File: rtl/conv_col_bram_writer.sv
// Accepts one multi-channel output column per handshake and streams it into
// the result BRAM as packed words, tracking column position within a frame.
module conv_col_bram_writer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_D,
  parameter int OUTPUT_CHANNELS = OUTPUT_CHANNELS_D,
  parameter int OUTPUT_COL_SIZE = OUTPUT_COL_SIZE_D,
  parameter int NUM_COLS        = NUM_COLS_D,
  parameter int BRAM_WIDTH      = BRAM_WIDTH_D,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_D
) (
  input  logic                                                           clk,
  input  logic                                                           rst,
  input  logic                                                           start,
  input  logic [ADDR_WIDTH-1:0]                                          base_addr,
  input  logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] col_in,
  input  logic                                                           valid_in,
  output logic                                                           in_ready,
  output logic [ADDR_WIDTH-1:0]                                          bram_addr,
  output logic [BRAM_WIDTH-1:0]                                          bram_din,
  output logic                                                           bram_en,
  output logic                                                           bram_we,
  output logic                                                           busy,
  output logic                                                           frame_done,
  output logic                                                           overflow
);

  localparam int LANES = BRAM_WIDTH / DATA_WIDTH;
  localparam int WPC   = ceil_div(OUTPUT_COL_SIZE, LANES);
  localparam int WPCOL = OUTPUT_CHANNELS * WPC;
  localparam int K_W   = (WPCOL > 1) ? $clog2(WPCOL) : 1;
  localparam int CI_W  = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

  wr_state_t                                                    state_r, next_state_s;
  logic [K_W-1:0]                                               k_r, next_k_s;
  logic [CI_W-1:0]                                              col_idx_r, next_col_s;
  logic [ADDR_WIDTH-1:0]                                        base_r;
  logic [OUTPUT_CHANNELS-1:0][OUTPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] buf_r;
  logic                                                         ovf_r;
  logic                                                         wr_r;
  logic [ADDR_WIDTH-1:0]                                        addr_r;
  logic [BRAM_WIDTH-1:0]                                        din_r;
  logic                                                         last_r;
  logic                                                         fd_r;

  logic                                                         in_ready_s;
  logic                                                         accept_s;
  logic                                                         drop_s;
  logic                                                         writing_s;
  logic                                                         frame_end_s;
  logic [ADDR_WIDTH-1:0]                                        addr_s;
  logic [BRAM_WIDTH-1:0]                                        word_s;

  col_word_packer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .OUTPUT_CHANNELS (OUTPUT_CHANNELS),
    .OUTPUT_COL_SIZE (OUTPUT_COL_SIZE),
    .BRAM_WIDTH      (BRAM_WIDTH)
  ) u_packer (
    .col  (buf_r),
    .k    (k_r),
    .word (word_s)
  );

  assign writing_s   = (state_r == ST_WRITE);
  assign in_ready_s  = (state_r == ST_IDLE) && !start;
  assign accept_s    = valid_in && in_ready_s;
  assign drop_s      = valid_in && !in_ready_s && !start;
  assign frame_end_s = writing_s && (k_r == K_W'(WPCOL - 1)) &&
                       (col_idx_r == CI_W'(NUM_COLS - 1));
  // Address arithmetic is truncated to ADDR_WIDTH so a frame may wrap silently.
  assign addr_s = base_r + ADDR_WIDTH'(col_idx_r) * ADDR_WIDTH'(WPCOL) + ADDR_WIDTH'(k_r);

  // Next-state, word counter and column counter sequencing.
  always_comb begin
    next_state_s = state_r;
    next_k_s     = k_r;
    next_col_s   = col_idx_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = ST_WRITE;
          next_k_s     = {K_W{1'b0}};
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (k_r == K_W'(WPCOL - 1)) begin
          next_state_s = ST_IDLE;
          next_k_s     = {K_W{1'b0}};
          if (col_idx_r == CI_W'(NUM_COLS - 1)) begin
            next_col_s = {CI_W{1'b0}};
          end else begin
            next_col_s = col_idx_r + CI_W'(1);
          end
        end else begin
          next_k_s = k_r + K_W'(1);
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_k_s     = {K_W{1'b0}};
      end
    endcase
  end

  // Control state, frame registers and the registered BRAM port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      k_r       <= {K_W{1'b0}};
      col_idx_r <= {CI_W{1'b0}};
      base_r    <= {ADDR_WIDTH{1'b0}};
      ovf_r     <= 1'b0;
      wr_r      <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      din_r     <= {BRAM_WIDTH{1'b0}};
      last_r    <= 1'b0;
      fd_r      <= 1'b0;
    end else if (start) begin
      state_r   <= ST_IDLE;
      k_r       <= {K_W{1'b0}};
      col_idx_r <= {CI_W{1'b0}};
      base_r    <= base_addr;
      ovf_r     <= 1'b0;
      wr_r      <= 1'b0;
      addr_r    <= {ADDR_WIDTH{1'b0}};
      din_r     <= {BRAM_WIDTH{1'b0}};
      last_r    <= 1'b0;
      fd_r      <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      k_r       <= next_k_s;
      col_idx_r <= next_col_s;
      if (drop_s) begin
        ovf_r <= 1'b1;
      end
      wr_r   <= writing_s;
      addr_r <= writing_s ? addr_s : {ADDR_WIDTH{1'b0}};
      din_r  <= writing_s ? word_s : {BRAM_WIDTH{1'b0}};
      last_r <= frame_end_s;
      fd_r   <= last_r;
    end
  end

  // Column buffer, loaded only when a column is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_r <= '{default: {DATA_WIDTH{1'b0}}};
    end else if (accept_s) begin
      buf_r <= col_in;
    end
  end

  assign in_ready   = in_ready_s;
  assign bram_addr  = addr_r;
  assign bram_din   = din_r;
  assign bram_en    = wr_r;
  assign bram_we    = wr_r;
  assign busy       = wr_r;
  assign frame_done = fd_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_conv_col_bram_writer.sv
// Randomized and directed bench for conv_col_bram_writer against a
// transaction-level model of expected BRAM writes per cycle.
module tb_conv_col_bram_writer;

  localparam int CH = 4;
  localparam int CS = 24;
  localparam int NC = 24;

  logic                          clk = 1'b0;
  logic                          rst = 1'b0;
  logic                          start = 1'b0;
  logic [11:0]                   base_addr = 12'h000;
  logic [CH-1:0][CS-1:0][15:0]   col_in = '0;
  logic                          valid_in = 1'b0;
  logic                          in_ready;
  logic [11:0]                   bram_addr;
  logic [255:0]                  bram_din;
  logic                          bram_en;
  logic                          bram_we;
  logic                          busy;
  logic                          frame_done;
  logic                          overflow;

  conv_col_bram_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .col_in     (col_in),
    .valid_in   (valid_in),
    .in_ready   (in_ready),
    .bram_addr  (bram_addr),
    .bram_din   (bram_din),
    .bram_en    (bram_en),
    .bram_we    (bram_we),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int free_at = 0;
  int m_col = 0;
  int fd_seen = 0;
  logic [11:0]  m_base = 12'h000;
  bit           m_ovf = 1'b0;
  logic [11:0]  exp_addr [int];
  logic [255:0] exp_din [int];
  bit           exp_fd [int];
  logic [15:0]  tcol [CH][CS];

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [255:0] model_word(input int ch, input int w);
    logic [255:0] r = '0;
    for (int l = 0; l < 16; l++)
      if (w * 16 + l < CS) r[l*16 +: 16] = tcol[ch][w*16 + l];
    return r;
  endfunction

  task automatic randomize_col();
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < CS; i++)
        tcol[c][i] = 16'($urandom);
  endtask

  // What the writer must do at clock edge e for the given inputs.
  task automatic model_edge(input int e, input bit s, input bit v, input logic [11:0] ba);
    if (s) begin
      for (int c = e; c < e + 12; c++) begin
        exp_addr.delete(c);
        exp_din.delete(c);
        exp_fd.delete(c);
      end
      free_at = e + 1;
      m_col   = 0;
      m_base  = ba;
      m_ovf   = 1'b0;
    end else if (v && e >= free_at) begin
      for (int k = 0; k < 8; k++) begin
        exp_addr[e + 1 + k] = m_base + 12'(m_col * 8 + k);
        exp_din[e + 1 + k]  = model_word(k / 2, k % 2);
      end
      if (m_col == NC - 1) begin
        exp_fd[e + 9] = 1'b1;
        m_col = 0;
      end else begin
        m_col++;
      end
      free_at = e + 9;
    end else if (v) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic check_outs();
    bit has;
    has = exp_addr.exists(cyc);
    check_eq("bram_we", bram_we, has);
    check_eq("bram_en", bram_en, has);
    check_eq("busy", busy, has);
    check_eq("bram_addr", bram_addr, has ? exp_addr[cyc] : 12'h000);
    check_eq("bram_din", bram_din, has ? exp_din[cyc] : 256'h0);
    check_eq("frame_done", frame_done, exp_fd.exists(cyc));
    check_eq("overflow", overflow, m_ovf);
    if (frame_done) fd_seen++;
  endtask

  task automatic tick(input bit s, input bit v, input logic [11:0] ba);
    start     = s;
    valid_in  = v;
    base_addr = ba;
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < CS; i++)
        col_in[c][i] = tcol[c][i];
    #1;
    check_eq("in_ready", in_ready, (cyc + 1 >= free_at) && !s);
    model_edge(cyc + 1, s, v, ba);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_outs();
  endtask

  task automatic check_reset_outs();
    check_eq("rst_we", bram_we, 1'b0);
    check_eq("rst_en", bram_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_addr", bram_addr, 12'h000);
    check_eq("rst_din", bram_din, 256'h0);
    check_eq("rst_fd", frame_done, 1'b0);
    check_eq("rst_ovf", overflow, 1'b0);
    check_eq("rst_ready", in_ready, 1'b1);
  endtask

  task automatic model_clear();
    exp_addr.delete();
    exp_din.delete();
    exp_fd.delete();
    m_col   = 0;
    m_base  = 12'h000;
    m_ovf   = 1'b0;
    free_at = cyc + 1;
  endtask

  initial begin
    logic [255:0] lo_exp;
    randomize_col();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    rst = 1'b1;
    model_clear();
    repeat (20) tick(1'b0, 1'b0, 12'h000);

    // Single column with a recognisable pattern.
    for (int c = 0; c < CH; c++)
      for (int i = 0; i < CS; i++)
        tcol[c][i] = 16'(c * 256 + i);
    tick(1'b1, 1'b0, 12'h100);
    tick(1'b0, 1'b1, 12'h000);
    tick(1'b0, 1'b0, 12'h000);
    tick(1'b0, 1'b0, 12'h000);
    lo_exp = '0;
    for (int l = 0; l < 8; l++) lo_exp[l*16 +: 16] = 16'(16'h0010 + l);
    check_eq("w101_addr", bram_addr, 12'h101);
    check_eq("w101_lo", bram_din[127:0], lo_exp);
    check_eq("w101_hi", bram_din[255:128], 128'h0);
    repeat (5) tick(1'b0, 1'b0, 12'h000);
    check_eq("w106_addr", bram_addr, 12'h106);
    check_eq("w106_lane0", bram_din[15:0], 16'h0300);
    tick(1'b0, 1'b0, 12'h000);
    check_eq("ready_back", in_ready, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 12'h000);

    // Full frame, back to back, data churning during writes.
    tick(1'b1, 1'b0, 12'(($urandom % 8) * 256));
    fd_seen = 0;
    repeat (NC * 9 + 9) begin
      randomize_col();
      tick(1'b0, 1'b1, 12'h000);
    end
    repeat (4) tick(1'b0, 1'b0, 12'h000);
    check_eq("fd_once", 32'(fd_seen), 32'd1);

    // Overflow while a column is in flight.
    randomize_col();
    tick(1'b1, 1'b0, 12'(($urandom)));
    tick(1'b0, 1'b1, 12'h000);
    tick(1'b0, 1'b0, 12'h000);
    tick(1'b0, 1'b0, 12'h000);
    randomize_col();
    tick(1'b0, 1'b1, 12'h000);
    repeat (8) tick(1'b0, 1'b0, 12'h000);
    check_eq("ovf_sticky", overflow, 1'b1);
    tick(1'b1, 1'b0, 12'h040);
    check_eq("ovf_clr", overflow, 1'b0);

    // Abort mid-column, then restart at a new base.
    randomize_col();
    tick(1'b0, 1'b1, 12'h000);
    repeat (3) tick(1'b0, 1'b0, 12'h000);
    tick(1'b1, 1'b0, 12'h200);
    check_eq("abort_we", bram_we, 1'b0);
    randomize_col();
    tick(1'b0, 1'b1, 12'h000);
    tick(1'b0, 1'b0, 12'h000);
    check_eq("abort_addr", bram_addr, 12'h200);
    repeat (9) tick(1'b0, 1'b0, 12'h000);

    // Address wrap, then start colliding with valid_in.
    tick(1'b1, 1'b0, 12'hFFC);
    tick(1'b0, 1'b1, 12'h000);
    repeat (5) tick(1'b0, 1'b0, 12'h000);
    check_eq("wrap_addr", bram_addr, 12'h000);
    repeat (5) tick(1'b0, 1'b0, 12'h000);
    tick(1'b1, 1'b1, 12'h000);
    check_eq("collide_ovf", overflow, 1'b0);
    tick(1'b0, 1'b0, 12'h000);
    check_eq("collide_we", bram_we, 1'b0);

    // Randomized traffic.
    repeat (900) begin
      randomize_col();
      tick(($urandom % 40) == 0, ($urandom % 3) == 0, 12'($urandom));
    end
    repeat (10) tick(1'b0, 1'b0, 12'h000);

    // Asynchronous reset in the middle of a write sequence.
    tick(1'b1, 1'b0, 12'h300);
    tick(1'b0, 1'b1, 12'h000);
    tick(1'b0, 1'b0, 12'h000);
    rst = 1'b0;
    #1;
    check_reset_outs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs();
    rst = 1'b1;
    model_clear();
    repeat (20) tick(1'b0, 1'b0, 12'h000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
